// File: rtl/alu_op_sequencer.sv
// Multicycle control sequencer feeding the combinational ALU: accepts one instruction
// over valid/ready and walks it through DECODE/EXEC/MEM/WB, driving addresses, alu_control and strobes.
module alu_op_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    output logic               instr_ready,
    output logic [4:0]         rs_addr,
    output logic [4:0]         rt_addr,
    output logic [4:0]         rd_addr,
    output logic [31:0]        imm,
    output logic [5:0]         alu_control,
    output logic               reg_we,
    output logic               wb_sel,
    output logic               mem_re,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               illegal,
    output logic               mem_err,
    output logic               busy,
    output logic [COUNT_W-1:0] retired_count
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_NOP   = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_STORE = 6'd3;
    localparam logic [5:0] OP_LOAD  = 6'd4;
    localparam logic [5:0] OP_MOVE  = 6'd5;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [31:0]      instr_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [5:0]       opcode;
    logic             op_defined;
    logic             is_load;
    logic             is_store;
    logic             mem_expired;
    logic             retire;

    assign opcode      = instr_q[31:26];
    assign op_defined  = (opcode <= OP_MOVE);
    assign is_load     = (opcode == OP_LOAD);
    assign is_store    = (opcode == OP_STORE);
    // The cycle after the last allowed strobe cycle is the expiry cycle; an ack there still wins.
    assign mem_expired = (tmo_cnt == TMO_W'(MEM_TIMEOUT));

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (instr_valid) next_state = S_DECODE;
            end
            S_DECODE: begin
                next_state = op_defined ? S_EXEC : S_IDLE;
            end
            S_EXEC: begin
                if (opcode == OP_NOP) begin
                    next_state = S_IDLE;
                    retire     = 1'b1;
                end else if (is_load || is_store) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (is_load) begin
                        next_state = S_WB;
                    end else begin
                        next_state = S_IDLE;
                        retire     = 1'b1;
                    end
                end else if (mem_expired) begin
                    next_state = S_IDLE;
                end
            end
            S_WB: begin
                next_state = S_IDLE;
                retire     = 1'b1;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            instr_q       <= '0;
            tmo_cnt       <= '0;
            retired_count <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && instr_valid) instr_q <= instr;
            if (state == S_EXEC) begin
                tmo_cnt <= '0;
            end else if (state == S_MEM && !mem_expired) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (retire) retired_count <= retired_count + COUNT_W'(1);
        end
    end

    // All outputs decode from state, so an asynchronous reset clears them in the same cycle.
    always_comb begin
        alu_control = 6'd0;
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            case (opcode)
                OP_ADD:   alu_control = 6'd1;
                OP_SUB:   alu_control = 6'd2;
                OP_STORE: alu_control = 6'd3;
                OP_LOAD:  alu_control = 6'd3;
                OP_MOVE:  alu_control = 6'd1;
                default:  alu_control = 6'd0;
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign instr_ready = (state == S_IDLE) && !reset;
    assign rs_addr     = busy ? instr_q[20:16] : 5'd0;
    assign rt_addr     = busy ? instr_q[15:11] : 5'd0;
    assign rd_addr     = busy ? instr_q[25:21] : 5'd0;
    assign imm         = busy ? {{16{instr_q[15]}}, instr_q[15:0]} : 32'd0;
    assign illegal     = (state == S_DECODE) && !op_defined;
    assign mem_re      = (state == S_MEM) && is_load && !mem_expired;
    assign mem_we      = (state == S_MEM) && is_store && !mem_expired;
    assign mem_err     = (state == S_MEM) && mem_expired && !mem_ack;
    assign reg_we      = (state == S_WB);
    assign wb_sel      = (state == S_WB) && is_load;

endmodule
